mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage load/store controller for an SRAM-like data bus.
// Holds the pipeline while one transaction is outstanding, replicates store
// data across byte lanes and extracts/extends load results.
// Optional feature: define MEM_ALIGN_EXC_EN to flag misaligned half/word
// accesses through adel/ades/badvaddr instead of issuing them; without it the
// misaligned low address bits are dropped.
//
// state | meaning
// IDLE  | no transaction; start when MEM stage holds a legal load/store
// ADDR  | data_req asserted with fields held, waiting for data_addr_ok
// DATA  | address accepted, waiting for data_data_ok
// DONE  | response in; pipeline released, load result valid unless cancelled
module mem_req_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memen,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        cancel;
    logic        ld_sign;
    logic        is_half;
    logic        is_word;
    logic        addr_err;
    logic        start;
    logic [31:0] aligned_addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // size 11 behaves as a word access everywhere
    assign is_half = (size == 2'b01);
    assign is_word = size[1];

`ifdef MEM_ALIGN_EXC_EN
    logic misaligned;
    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    // Only a fresh MEM-stage access in IDLE can fault; flush suppresses it
    assign addr_err   = resetn && (state == IDLE) && memen && !flush && misaligned;
    assign adel       = addr_err && !memwrite;
    assign ades       = addr_err && memwrite;
    assign badvaddr   = addr_err ? addr : 32'h0;
`else
    assign addr_err   = 1'b0;
    assign adel       = 1'b0;
    assign ades       = 1'b0;
    assign badvaddr   = 32'h0;
`endif

    assign start = resetn && (state == IDLE) && memen && !flush && !addr_err;

    // The IDLE term holds the pipeline in the same cycle the access is seen
    assign stall = resetn && (start || (state == ADDR) || (state == DATA));

    // Drop low address bits a half/word access cannot use
    always_comb begin
        aligned_addr = addr;
        if (is_word) begin
            aligned_addr[1:0] = 2'b00;
        end else if (is_half) begin
            aligned_addr[0] = 1'b0;
        end
    end

    // Replicate right-aligned store data onto every lane the access may hit
    always_comb begin
        case (size)
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    end

    // Extract the addressed lane of the response and extend it
    always_comb begin
        case (data_addr[1:0])
            2'b00:   ld_byte = data_rdata[7:0];
            2'b01:   ld_byte = data_rdata[15:8];
            2'b10:   ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (data_size)
            2'b00:   load_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: load_data = data_rdata;
        endcase
    end

    // Sequencer: request issue, response capture and cancel tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cancel      <= 1'b0;
            ld_sign     <= 1'b0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'b00;
            data_addr   <= 32'h0;
            data_wdata  <= 32'h0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ADDR;
                        data_req   <= 1'b1;
                        data_wr    <= memwrite;
                        data_size  <= size;
                        data_addr  <= aligned_addr;
                        data_wdata <= store_data;
                        ld_sign    <= sign_ext;
                    end
                end
                ADDR: begin
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                    // data_data_ok alone is not a response until the address is taken
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            state       <= DONE;
                            rdata_valid <= !data_wr && !cancel && !flush;
                            if (!data_wr) begin
                                rdata <= load_data;
                            end
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (flush) begin
                        cancel <= 1'b1;
                    end
                    if (data_data_ok) begin
                        state       <= DONE;
                        rdata_valid <= !data_wr && !cancel && !flush;
                        if (!data_wr) begin
                            rdata <= load_data;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    cancel <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: transaction-level model with per-cycle compare.
module tb_mem_req_ctrl;

    logic        clk;
    logic        resetn;
    logic        memen;
    logic        memwrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    mem_req_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .memen       (memen),
        .memwrite    (memwrite),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .adel        (adel),
        .ades        (ades),
        .badvaddr    (badvaddr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // expectations for the current cycle, set by the driver
    logic        chk_en;
    logic        exp_stall, exp_req, exp_wr, exp_valid, exp_chk_rdata;
    logic        exp_adel, exp_ades;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_bad;

    // observations used by the directed literal checks
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    int          valid_cnt = 0;
    int          adel_cnt  = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic [31:0] obs_addr  = 32'h0;
    logic [31:0] obs_wdata = 32'h0;
    logic        obs_wr    = 1'b0;
    logic [1:0]  obs_size  = 2'b00;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---- behavioural model ----
    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        int r;
        r = int'(a % 4);
        if (sz == 2'b01) return (r % 2) != 0;
        if (sz[1])       return r != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return a - (a % 2);
        if (sz[1])       return a - (a % 4);
        return a;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] v, input logic [1:0] sz,
                                          input logic [31:0] a, input logic s);
        logic [31:0] x;
        logic [31:0] al;
        int          sh;
        al = m_addr(sz, a);
        if (sz == 2'b00) begin
            sh = 8 * int'(al % 4);
            x  = (v >> sh) % 256;
            if (s && x >= 32'd128) x = x + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = 8 * int'(al % 4);
            x  = (v >> sh) % 65536;
            if (s && x >= 32'd32768) x = x + 32'hFFFF_0000;
        end else begin
            x = v;
        end
        return x;
    endfunction

    // ---- compare process ----
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("stall", stall, exp_stall);
            chk1("data_req", data_req, exp_req);
            if (exp_req) begin
                chk1("data_wr", data_wr, exp_wr);
                chk2("data_size", data_size, exp_size);
                chk32("data_addr", data_addr, exp_addr);
                if (exp_wr) chk32("data_wdata", data_wdata, exp_wdata);
            end
            chk1("rdata_valid", rdata_valid, exp_valid);
            if (exp_valid || exp_chk_rdata) chk32("rdata", rdata, exp_rdata);
            chk1("adel", adel, exp_adel);
            chk1("ades", ades, exp_ades);
            chk32("badvaddr", badvaddr, exp_bad);
            if (stall) stall_cnt++;
            if (adel) adel_cnt++;
            if (rdata_valid) begin
                valid_cnt++;
                obs_rdata = rdata;
            end
            if (data_req) begin
                req_cnt++;
                obs_addr  = data_addr;
                obs_wdata = data_wdata;
                obs_wr    = data_wr;
                obs_size  = data_size;
            end
        end
    end

    // ---- driver helpers ----
    task automatic exp_idle();
        exp_stall = 0; exp_req = 0; exp_wr = 0; exp_size = 0;
        exp_addr = 0; exp_wdata = 0; exp_valid = 0; exp_chk_rdata = 0;
        exp_rdata = 0; exp_adel = 0; exp_ades = 0; exp_bad = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        memen        = 0;
        memwrite     = 1'($urandom_range(0, 1));
        size         = 2'($urandom_range(0, 3));
        sign_ext     = 1'($urandom_range(0, 1));
        addr         = $urandom;
        wdata        = $urandom;
        flush        = 1'($urandom_range(0, 1));
        data_addr_ok = 1'($urandom_range(0, 1));
        data_data_ok = 1'($urandom_range(0, 1));
        data_rdata   = $urandom;
        exp_idle();
        cyc();
    endtask

    // One MEM-stage instruction from its first cycle through DONE.
    // fl_at: -1 no flush, 0 flush in the IDLE cycle, k>0 flush k cycles in.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int adly, input int ddly, input int fl_at,
                           input logic [31:0] rd);
        int   last;
        logic exc;
        logic flushed;
        exc = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
        exc = m_misal(sz, a) && (fl_at != 0);
`endif
        last    = (fl_at == 0 || exc) ? 0 : 2 + adly + ddly;
        flushed = 1'b0;
        for (int c = 0; c <= last; c++) begin
            memen        = 1;
            memwrite     = wr;
            size         = sz;
            sign_ext     = sgn;
            addr         = a;
            wdata        = wd;
            flush        = (c == fl_at) && !(last > 0 && c == last);
            if (flush && c > 0) flushed = 1'b1;
            data_addr_ok = 0;
            data_data_ok = 0;
            data_rdata   = $urandom;
            exp_idle();
            if (c == 0) begin
                exp_stall = !flush && !exc;
                exp_adel  = exc && !wr;
                exp_ades  = exc && wr;
                exp_bad   = exc ? a : 32'h0;
            end else if (c <= 1 + adly) begin
                exp_stall = 1; exp_req = 1; exp_wr = wr; exp_size = sz;
                exp_addr  = m_addr(sz, a);
                exp_wdata = m_wdata(sz, wd);
                data_addr_ok = (c == 1 + adly);
                if (data_addr_ok && ddly == 0) begin
                    data_data_ok = 1;
                    data_rdata   = rd;
                end else if (!data_addr_ok) begin
                    data_data_ok = 1'($urandom_range(0, 1));
                end
            end else if (c < last) begin
                exp_stall = 1;
                if (c == 1 + adly + ddly) begin
                    data_data_ok = 1;
                    data_rdata   = rd;
                end
            end else begin
                data_data_ok = 1'($urandom_range(0, 1));
                exp_valid    = !wr && !flushed;
                exp_rdata    = m_load(rd, sz, a, sgn);
            end
            cyc();
        end
    endtask

    int s0, r0, v0, a0;
    int fl;
    int ad, dd;
    logic [31:0] ra;

    initial begin
        clk = 0; resetn = 0; chk_en = 0;
        memen = 0; memwrite = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        exp_idle();
        exp_chk_rdata = 1;
        chk_en = 1;
        cyc();
        cyc();
        resetn = 1;
        idle_cyc();

        // LW immediate handshakes
        s0 = stall_cnt; r0 = req_cnt; v0 = valid_cnt;
        run_txn(0, 2'b10, 0, 32'h1000, 0, 0, 1, -1, 32'hDEAD_BEEF);
        chkint("lw_stall_cycles", stall_cnt - s0, 3);
        chkint("lw_req_cycles", req_cnt - r0, 1);
        chkint("lw_valid_cycles", valid_cnt - v0, 1);
        chk32("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        idle_cyc();

        // LB / LBU on lane 3
        v0 = valid_cnt;
        run_txn(0, 2'b00, 1, 32'h1003, 0, 0, 1, -1, 32'h80FF_FF7F);
        chk32("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        run_txn(0, 2'b00, 0, 32'h1003, 0, 1, 2, -1, 32'h80FF_FF7F);
        chk32("lbu_rdata", obs_rdata, 32'h0000_0080);
        chkint("lb_valid_cycles", valid_cnt - v0, 2);

        // SH with delayed address acceptance
        r0 = req_cnt; s0 = stall_cnt; v0 = valid_cnt;
        run_txn(1, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 4, 1, -1, $urandom);
        chkint("sh_req_cycles", req_cnt - r0, 5);
        chkint("sh_stall_cycles", stall_cnt - s0, 7);
        chk32("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        chk2("sh_size", obs_size, 2'b01);
        chk1("sh_wr", obs_wr, 1'b1);
        chkint("sh_no_valid", valid_cnt - v0, 0);
        idle_cyc();

        // LW flushed in DATA, data_ok two cycles later
        s0 = stall_cnt; v0 = valid_cnt;
        run_txn(0, 2'b10, 0, 32'h3000, 0, 0, 3, 2, 32'h1234_5678);
        chkint("flush_stall_cycles", stall_cnt - s0, 5);
        chkint("flush_no_valid", valid_cnt - v0, 0);
        idle_cyc();

        // Misaligned LW
        r0 = req_cnt; a0 = adel_cnt;
        run_txn(0, 2'b10, 0, 32'h1002, 0, 0, 1, -1, 32'h0BAD_F00D);
`ifdef MEM_ALIGN_EXC_EN
        chkint("misal_no_req", req_cnt - r0, 0);
        chkint("misal_adel_cycles", adel_cnt - a0, 1);
`else
        chk32("misal_addr", obs_addr, 32'h0000_1000);
        chkint("misal_req_cycles", req_cnt - r0, 1);
        chkint("misal_no_adel", adel_cnt - a0, 0);
`endif
        idle_cyc();

        // Reset pulsed while waiting in DATA
        memen = 1; memwrite = 0; size = 2'b10; sign_ext = 0; addr = 32'h4000;
        wdata = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0;
        exp_idle(); exp_stall = 1;
        cyc();
        data_addr_ok = 1;
        exp_idle(); exp_stall = 1; exp_req = 1; exp_wr = 0; exp_size = 2'b10;
        exp_addr = 32'h4000;
        cyc();
        data_addr_ok = 0;
        exp_idle(); exp_stall = 1;
        @(negedge clk);
        #1;
        chk_en = 0;
        memen  = 0;
        resetn = 0;
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_req", data_req, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1;
        v0 = valid_cnt;
        s0 = stall_cnt;
        exp_idle();
        exp_chk_rdata = 1;
        chk_en = 1;
        data_data_ok = 1;
        data_rdata   = 32'hFFFF_FFFF;
        cyc();
        data_data_ok = 0;
        exp_idle();
        exp_chk_rdata = 1;
        cyc();
        chkint("rst_stray_valid", valid_cnt - v0, 0);
        chkint("rst_stray_stall", stall_cnt - s0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) idle_cyc();
            ad = int'($urandom_range(0, 3));
            dd = int'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       fl = 0;
                1, 2:    fl = int'($urandom_range(1, 1 + ad + dd));
                default: fl = -1;
            endcase
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ra, $urandom, ad, dd, fl, $urandom);
        end
        idle_cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
